// File: rtl/pipelined_rca_adder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_rca_adder_pkg : shared constants and sizing helper (rev 1.0)
// ----------------------------------------------------------------------------
package pipelined_rca_adder_pkg;

  localparam int SLICE_DEFAULT = 4;
  localparam int WIDTH_DEFAULT = 16;

  function automatic int num_stages(input int width, input int slice);
    return width / slice;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_rca_adder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_rca_adder_if : operand/result valid-ready bus (rev 1.0)
// ----------------------------------------------------------------------------
interface pipelined_rca_adder_if
  import pipelined_rca_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface
`default_nettype wire

// File: rtl/pipelined_rca_adder_rca_slice.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rca_slice : SLICE-bit combinational ripple-carry adder (rev 1.0)
// ----------------------------------------------------------------------------
module rca_slice
  import pipelined_rca_adder_pkg::*;
#(
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [SLICE:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[SLICE];
  // carry into the top bit; XOR with cout_o gives signed overflow
  assign cmsb_o = carry[SLICE-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_rca_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_rca_adder : elastic pipelined ripple-carry adder/subtractor (rev 1.0)
// ----------------------------------------------------------------------------
module pipelined_rca_adder
  import pipelined_rca_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_rca_adder_if.slave bus
);

  localparam int NUM_STAGES = num_stages(WIDTH, SLICE);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t                  stage_q [NUM_STAGES];
  stage_t                  in_stage;
  logic [NUM_STAGES-1:0]   valid;
  logic [NUM_STAGES-1:0]   ready;

  always_comb begin
    in_stage       = '0;
    in_stage.valid = bus.in_valid;
    in_stage.carry = bus.sub | bus.cin;
    in_stage.a     = bus.a;
    in_stage.b     = bus.sub ? ~bus.b : bus.b;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           stage_d;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;

    if (k == 0) begin : g_src_input
      assign src = in_stage;
    end else begin : g_src_prev
      assign src = stage_q[k-1];
    end

    assign valid[k] = stage_q[k].valid;
    // Flattened form of ready_k = !valid_k || ready_{k+1}: a stage can take
    // data unless it and every stage downstream are full and the sink stalls.
    assign ready[k] = bus.out_ready || !(&valid[NUM_STAGES-1:k]);

    rca_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a_i    (src.a[k*SLICE +: SLICE]),
      .b_i    (src.b[k*SLICE +: SLICE]),
      .cin_i  (src.carry),
      .sum_o  (slice_sum),
      .cout_o (slice_cout),
      .cmsb_o (slice_cmsb)
    );

    always_comb begin
      stage_d                        = src;
      stage_d.sum[k*SLICE +: SLICE]  = slice_sum;
      stage_d.carry                  = slice_cout;
      stage_d.ovf                    = slice_cmsb ^ slice_cout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q[k] <= '0;
      end else if (ready[k]) begin
        if (src.valid) begin
          stage_q[k] <= stage_d;
        end else begin
          stage_q[k].valid <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = ready[0];
  assign bus.out_valid = stage_q[NUM_STAGES-1].valid;
  assign bus.sum       = stage_q[NUM_STAGES-1].sum;
  assign bus.cout      = stage_q[NUM_STAGES-1].carry;
  assign bus.ovf       = stage_q[NUM_STAGES-1].ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_rca_adder.sv
`default_nettype none
// tb_pipelined_rca_adder : vector table, directed handshake sequences and
// randomized traffic against an arithmetic reference model.
module tb_pipelined_rca_adder;
  import pipelined_rca_adder_pkg::*;

  localparam int WIDTH      = 16;
  localparam int SLICE      = 4;
  localparam int NUM_STAGES = num_stages(WIDTH, SLICE);

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pipelined_rca_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_rca_adder #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  res_t exp_q[$];
  int   out_cyc[$];
  logic fire       = 1'b0;
  logic in_rdy_s   = 1'b0;
  logic held_valid = 1'b0;
  res_t held;

  // Reference: signed/unsigned integer arithmetic, no bit-level carries
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    int   sa, sb, r;
    res_t m;
    sa     = int'($signed(a));
    sb     = int'($signed(b));
    r      = sub ? (sa - sb) : (sa + sb + int'(cin));
    m.sum  = r[15:0];
    m.ovf  = (r > 32767) || (r < -32768);
    m.cout = sub ? (a >= b) : ((int'(a) + int'(b) + int'(cin)) > 65535);
    return m;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_res(input string name, input res_t act, input res_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got sum=%04h cout=%0b ovf=%0b, required sum=%04h cout=%0b ovf=%0b",
               name, act.sum, act.cout, act.ovf, req.sum, req.cout, req.ovf);
    end
  endtask

  task automatic check_out();
    res_t g;
    g = '{sum: bus.sum, cout: bus.cout, ovf: bus.ovf};
    out_cyc.push_back(cyc);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_result: got sum=%04h, required no result", bus.sum);
    end else begin
      check_res("result", g, exp_q.pop_front());
    end
  endtask

  // One clock: sample at the falling edge, return 1 time unit past the rising edge
  task automatic step();
    @(negedge clk);
    fire     = bus.in_valid && bus.in_ready;
    in_rdy_s = bus.in_ready;
    if (held_valid) begin
      check_val("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check_res("stall_hold", '{sum: bus.sum, cout: bus.cout, ovf: bus.ovf}, held);
    end
    if (bus.out_valid && bus.out_ready) check_out();
    held_valid = bus.out_valid && !bus.out_ready;
    held       = '{sum: bus.sum, cout: bus.cout, ovf: bus.ovf};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input res_t e);
    int n;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!fire && n < 50);
    if (fire) exp_q.push_back(e);
    else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", n);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic latency_check(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub, input res_t e);
    int n;
    bus.out_ready = 1'b1;
    send(a, b, cin, sub, e);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check_val(name, 32'(n), 32'(NUM_STAGES - 1));
    drain();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vt [10];
    int   acc_at_drop, stall_left, idx, stale, acc;
    logic rdy_ok;
    logic [15:0] ra, rb;
    logic rcin, rsub, pending;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    vt[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, '{16'h0001, 1'b0, 1'b0}};
    vt[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    vt[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
    vt[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
    vt[9] = '{16'h0000, 16'h8000, 1'b0, 1'b1, '{16'h8000, 1'b0, 1'b1}};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    check_val("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("reset_sum",       32'(bus.sum),       32'd0);
    check_val("reset_cout",      32'(bus.cout),      32'd0);
    check_val("reset_ovf",       32'(bus.ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Single op latency
    latency_check("latency_edges", 16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0});

    // Vector table, issued back to back
    out_cyc.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].exp);
    drain();
    check_val("table_count", 32'(out_cyc.size()), 32'd10);
    if (out_cyc.size() == 10)
      check_val("table_consecutive", 32'(out_cyc[9] - out_cyc[0]), 32'd9);

    // Backpressure: 6 ops, sink stalls for 5 cycles at the first result
    bus.out_ready = 1'b1;
    idx = 1;
    stall_left = -1;
    acc_at_drop = -1;
    for (int c = 0; c < 80 && (idx <= 6 || exp_q.size() > 0); c++) begin
      if (idx <= 6) begin
        bus.a = 16'(idx); bus.b = 16'h0100; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (fire) begin
        exp_q.push_back(model(16'(idx), 16'h0100, 1'b0, 1'b0));
        idx++;
      end
      if (!in_rdy_s && acc_at_drop < 0) acc_at_drop = idx - 1;
      if (stall_left < 0 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        stall_left = 5;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) bus.out_ready = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check_val("bp_accepted_before_full", 32'(acc_at_drop), 32'd4);
    check_val("bp_all_sent", 32'(idx), 32'd7);
    drain();

    // Bubble collapse with the sink stalled
    bus.out_ready = 1'b0;
    rdy_ok = 1'b1;
    send(16'h0010, 16'h0001, 1'b0, 1'b0, model(16'h0010, 16'h0001, 1'b0, 1'b0));
    repeat (2) begin step(); rdy_ok &= in_rdy_s; end
    send(16'h0020, 16'h0002, 1'b0, 1'b0, model(16'h0020, 16'h0002, 1'b0, 1'b0));
    repeat (3) begin step(); rdy_ok &= in_rdy_s; end
    check_val("bubble_in_ready_held", 32'(rdy_ok), 32'd1);
    idx = 3;
    for (int c = 0; c < 6; c++) begin
      if (idx <= 5) begin
        bus.a = 16'(idx * 16); bus.b = 16'(idx); bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
      end
      step();
      if (fire) begin
        exp_q.push_back(model(16'(idx * 16), 16'(idx), 1'b0, 1'b0));
        idx++;
      end
    end
    acc = idx - 3;
    check_val("bubble_extra_accepted", 32'(acc), 32'd2);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (idx <= 5) begin
      send(16'(idx * 16), 16'(idx), 1'b0, 1'b0, model(16'(idx * 16), 16'(idx), 1'b0, 1'b0));
      idx++;
    end
    drain();

    // Asynchronous reset with three ops in flight
    bus.out_ready = 1'b1;
    send(16'hC000, 16'h8000, 1'b0, 1'b0, model(16'hC000, 16'h8000, 1'b0, 1'b0));
    send(16'h0001, 16'h0002, 1'b0, 1'b0, model(16'h0001, 16'h0002, 1'b0, 1'b0));
    send(16'h0003, 16'h0004, 1'b0, 1'b0, model(16'h0003, 16'h0004, 1'b0, 1'b0));
    step();
    check_val("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    check_val("pre_reset_sum",       32'(bus.sum),       32'h4000);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("async_reset_sum",       32'(bus.sum),       32'd0);
    check_val("async_reset_cout",      32'(bus.cout),      32'd0);
    check_val("async_reset_ovf",       32'(bus.ovf),       32'd0);
    exp_q.delete();
    held_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    stale = 0;
    repeat (8) begin
      step();
      if (bus.out_valid) stale++;
    end
    check_val("no_stale_results", 32'(stale), 32'd0);
    latency_check("post_reset_latency", 16'h0002, 16'h0003, 1'b0, 1'b0, '{16'h0005, 1'b0, 1'b0});

    // Randomized traffic with random source gaps and sink stalls
    pending = 1'b0;
    ra = '0; rb = '0; rcin = 1'b0; rsub = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        ra   = ($urandom_range(0, 3) == 0) ? 16'h7FFF + 16'($urandom_range(0, 2)) : 16'($urandom);
        rb   = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1)) : 16'($urandom);
        rcin = 1'($urandom_range(0, 1));
        rsub = 1'($urandom_range(0, 1));
        bus.a = ra; bus.b = rb; bus.cin = rcin; bus.sub = rsub;
        bus.in_valid = 1'b1;
        pending = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (fire) begin
        exp_q.push_back(model(ra, rb, rcin, rsub));
        pending = 1'b0;
        bus.in_valid = 1'b0;
      end
    end
    bus.out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It is the successor to the combinational 4-bit ripple adder used in the double-dabble datapath.
- Splits a WIDTH-bit add into SLICE-bit ripple slices, one register stage per slice, so wide BCD/binary adds close timing at higher clock rates.
- Valid/ready handshake on input and output, with per-stage bubble collapsing and signed overflow detection.

Parameters:
- WIDTH, 16: operand/sum width in bits; must be a multiple of SLICE and at least SLICE.
- SLICE, 4: bits added per pipeline stage (ripple-carry slice width).
- NUM_STAGES, WIDTH/SLICE: derived, not overridable; pipeline depth and latency in cycles.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A (unsigned or two's complement)
- b  in  WIDTH  operand B
- cin  in  1  carry-in, used when sub=0
- sub  in  1  1 = A-B, 0 = A+B+cin
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of MSB (for subtraction, 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, on rst_n.
- Reset values: every stage valid = 0 and all stage data = 0. Outputs out_valid=0, sum=0, cout=0, ovf=0. in_ready reads 1 once rst_n is high.
- Operand conditioning at input: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin (cin is ignored when sub=1).
- Stage k (k = 0..NUM_STAGES-1) holds: valid_k, carry_k, the sum bits for slices 0..k, and the not-yet-added slices of a and b_eff.
- Stage 0 adds slice 0 combinationally from the inputs with c0. Stage k adds slice k using carry_{k-1} and registered operands.
- Only the final slice computes ovf = carry into MSB XOR carry out of MSB.
- Output is taken directly from the last stage: out_valid = valid_{N-1}. sum, cout and ovf are registered.
- Handshake and latency:
  - Transfer occurs when valid && ready on the same edge.
  - Zero-stall latency is exactly NUM_STAGES cycles: operands accepted on edge t produce out_valid high after edge t+NUM_STAGES-1. That is 4 cycles at defaults.
  - Stage ready: ready_k = !valid_k || ready_{k+1}; ready_N = out_ready. in_ready = ready_0. Bubbles collapse; a fully idle pipe accepts every cycle.
  - Throughput: one operation per cycle while out_ready=1.
  - When out_valid=1 and out_ready=0, the output stage holds sum/cout/ovf stable. Upstream stages keep advancing into empty stages until the pipe is full, then in_ready=0.
  - Order is strictly preserved; no result is dropped or duplicated.
  - Simultaneous drain and fill of a full stage is allowed: the stage loads new data on the same edge its old data leaves.
- Data integrity:
  - Stage data registers load only when the stage accepts.
  - When valid=0, stage data contents are don't-care, but sum/cout/ovf must not change while out_valid=1 is stalled.
  - in_valid while in_ready=0: operands are not captured; the source must hold them.
- Reset mid-operation: all in-flight results are discarded and outputs return to reset values immediately on assertion (asynchronous).
- Arithmetic: results are modulo 2^WIDTH. cout is the true carry-out of A + b_eff + c0.
- Generate-based: no hard-coded widths.

Decomposition:
- Shared package:
  - SLICE default constant.
  - Function num_stages(width, slice).
  - Packed stage-register typedef {valid, carry, sum bits, remaining a bits, remaining b bits}, parametrised via the package function.
- One sub-module: rca_slice (parametrised SLICE-bit combinational ripple adder with cin/cout, plus carry-into-MSB output for overflow). Instantiated NUM_STAGES times by generate.

Test Plan:
- Basic add, defaults, out_ready=1: a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0, out_valid asserted exactly 4 cycles after acceptance.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1. Issue back-to-back; results arrive on consecutive cycles.
- Subtract: sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: stream 6 ops (a=i, b=0x0100, i=1..6) with out_ready held 0 from the first out_valid for 5 cycles:
  - in_ready drops after 4 ops are held.
  - The first result 0x0101 stays stable.
  - After release, results 0x0101..0x0106 appear in order, none lost.
- Bubble collapse: accept one op, idle 2 cycles, accept a second, hold out_ready=0 -> the second op advances to stage directly behind the output stage; in_ready stays 1 until the pipe is full.
- Reset mid-flight: assert rst_n=0 asynchronously with 3 ops in flight -> out_valid=0, sum=0, cout=0, ovf=0 immediately. After release, no stale results appear and a new op 0x0002+0x0003 returns 0x0005 after 4 cycles.
